// File: rtl/uart_reporter.sv
// Event/score reporter: queues game events and score requests and serialises them
// as ASCII bytes towards the uart transmitter (one byte per uart frame).
package enum_type;
    typedef enum logic [2:0] {
        NOEVENT, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV
    } control_type;
endpackage

module uart_reporter
    import enum_type::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SCORE_MAX = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        event_valid,
    input  control_type event_code,
    output logic        event_ready,
    input  logic        score_valid,
    input  logic [13:0] score,
    output logic        overflow,
    output logic        busy,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        is_transmitting
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [13:0]   SMAX = 14'(SCORE_MAX);

    typedef enum logic [2:0] {IDLE, CONVERT, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t            state_q, state_d;
    control_type       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [2:0]        len_q, len_d, idx_q, idx_d;
    logic [13:0]       work_q, work_d, score_reg_q, weight;
    logic [1:0]        wsel_q, wsel_d;
    logic [3:0][3:0]   dig_q, dig_d;
    logic              pending_q, overflow_q;
    logic              ev, push, pop, drop, consume;

    function automatic logic [7:0] map_event(input control_type c);
        case (c)
            LEFT:       return 8'h61;
            RIGHT:      return 8'h64;
            DOWN:       return 8'h77;
            DROP:       return 8'h73;
            HOLD:       return 8'h63;
            ROTATE:     return 8'h78;
            ROTATE_REV: return 8'h7A;
            default:    return 8'h00;
        endcase
    endfunction

    // Score line layout: 'S', four ASCII digits (thousands first), CR, LF.
    function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [3:0][3:0] dig);
        case (idx)
            3'd0:    return 8'h53;
            3'd1:    return {4'h3, dig[3]};
            3'd2:    return {4'h3, dig[2]};
            3'd3:    return {4'h3, dig[1]};
            3'd4:    return {4'h3, dig[0]};
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign ev          = event_valid && (event_code != NOEVENT);
    assign push        = ev && (count_q != FULL);
    assign drop        = ev && (count_q == FULL);
    assign event_ready = (count_q != FULL);
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE);
    assign tx_byte     = tx_byte_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        len_d     = len_q;
        idx_d     = idx_q;
        work_d    = work_q;
        wsel_d    = wsel_q;
        dig_d     = dig_q;
        pop       = 1'b0;
        consume   = 1'b0;
        transmit  = 1'b0;
        case (wsel_q)
            2'd0:    weight = 14'd1000;
            2'd1:    weight = 14'd100;
            default: weight = 14'd10;
        endcase
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    consume = 1'b1;
                    work_d  = score_reg_q;
                    wsel_d  = '0;
                    dig_d   = '0;
                    state_d = CONVERT;
                end else if (count_q != '0) begin
                    pop       = 1'b1;
                    tx_byte_d = map_event(mem_q[rd_ptr_q]);
                    len_d     = 3'd1;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            CONVERT: begin
                // Repeated subtraction, one step per cycle; the remainder below 10 is the units digit.
                if (work_q >= weight) begin
                    work_d                  = work_q - weight;
                    dig_d[2'd3 - wsel_q]    = dig_q[2'd3 - wsel_q] + 4'd1;
                end else if (wsel_q == 2'd2) begin
                    dig_d[0]  = work_q[3:0];
                    tx_byte_d = 8'h53;
                    len_d     = 3'd7;
                    idx_d     = '0;
                    state_d   = SEND;
                end else begin
                    wsel_d = wsel_q + 2'd1;
                end
            end
            SEND: begin
                if (!is_transmitting) begin
                    transmit = 1'b1;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (is_transmitting) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!is_transmitting) begin
                    if ((idx_q + 3'd1) < len_q) begin
                        idx_d     = idx_q + 3'd1;
                        tx_byte_d = msg_byte(idx_q + 3'd1, dig_q);
                        state_d   = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= event_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_byte_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            work_q      <= '0;
            wsel_q      <= '0;
            dig_q       <= '0;
            score_reg_q <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tx_byte_q <= tx_byte_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            work_q    <= work_d;
            wsel_q    <= wsel_d;
            dig_q     <= dig_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop) overflow_q <= 1'b1;
            // A new request in the same cycle as IDLE consumes the old one keeps a line pending.
            if (score_valid) begin
                score_reg_q <= (score > SMAX) ? SMAX : score;
                pending_q   <= 1'b1;
            end else if (consume) begin
                pending_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_reporter.sv
// Directed bench for uart_reporter: a behavioural uart collects transmitted bytes,
// which are compared against hand-computed ASCII sequences.
module tb_uart_reporter;
    import enum_type::*;

    localparam int DEPTH = 16;
    localparam int FRAME = 8;

    logic        clk, rst;
    logic        event_valid, score_valid, is_transmitting;
    control_type event_code;
    logic [13:0] score;
    logic        event_ready, overflow, busy, transmit;
    logic [7:0]  tx_byte;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int proto_err = 0;
    logic stall = 1'b0;
    logic deaf = 1'b0;
    logic prev_tx = 1'b0;
    logic [7:0] rx [$];
    logic [7:0] exp_q [$];

    uart_reporter #(.DEPTH(DEPTH), .SCORE_MAX(9999)) dut (
        .clk(clk), .rst(rst),
        .event_valid(event_valid), .event_code(event_code), .event_ready(event_ready),
        .score_valid(score_valid), .score(score),
        .overflow(overflow), .busy(busy), .transmit(transmit), .tx_byte(tx_byte),
        .is_transmitting(is_transmitting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign is_transmitting = (busy_cnt != 0);

    // Behavioural uart: latch byte on strobe, stay busy FRAME cycles (frozen while stalled).
    always @(posedge clk) begin
        prev_tx <= transmit;
        if (transmit && (is_transmitting || prev_tx)) proto_err <= proto_err + 1;
        if (rst) begin
            busy_cnt <= 0;
        end else if (transmit && !deaf) begin
            rx.push_back(tx_byte);
            busy_cnt <= FRAME;
        end else if (busy_cnt != 0 && !stall) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    function automatic logic [7:0] ascii_of(input control_type c);
        case (c)
            LEFT: return 8'h61;  RIGHT: return 8'h64;  DOWN: return 8'h77;
            DROP: return 8'h73;  HOLD: return 8'h63;   ROTATE: return 8'h78;
            ROTATE_REV: return 8'h7A;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input control_type c);
        event_valid = 1'b1;
        event_code  = c;
        @(negedge clk);
        event_valid = 1'b0;
        event_code  = NOEVENT;
    endtask

    task automatic req_score(input logic [13:0] v);
        score_valid = 1'b1;
        score       = v;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n);
        for (int c = 0; c < 4000 && rx.size() < n; c++) @(negedge clk);
        check(tag, 32'(rx.size() >= n), 32'd1);
    endtask

    // Compare the whole received stream against exp_q, then require a quiet line.
    task automatic check_stream(input string tag);
        wait_rx({tag, "_timeout"}, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(exp_q[i]));
        repeat (150) @(negedge clk);
        check({tag, "_count"}, 32'(rx.size()), 32'(exp_q.size()));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; event_valid = 1'b0; event_code = NOEVENT; score_valid = 1'b0; score = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_txbyte", 32'(tx_byte), 32'h00);
        check("rst_ready", 32'(event_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: reset while parked in WAIT_HI (uart never raises busy)
        deaf = 1'b1;
        push_one(LEFT);
        repeat (5) @(negedge clk);
        check("t1_busy_pre", 32'(busy), 32'd1);
        check("t1_txbyte_pre", 32'(tx_byte), 32'h61);
        rst = 1'b1;
        #1;
        check("t1_busy_rst", 32'(busy), 32'd0);
        check("t1_txbyte_rst", 32'(tx_byte), 32'h00);
        check("t1_transmit_rst", 32'(transmit), 32'd0);
        check("t1_ready_rst", 32'(event_ready), 32'd1);
        check("t1_overflow_rst", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        deaf = 1'b0;
        rx.delete();
        @(negedge clk);
        push_one(DOWN);
        exp_q = '{8'h77};
        check_stream("t1_after");

        // T2: back-to-back events
        push_one(RIGHT);
        push_one(HOLD);
        push_one(ROTATE_REV);
        exp_q = '{8'h64, 8'h63, 8'h7A};
        check_stream("t2");

        // T3: score lines, including saturation
        req_score(14'd427);
        exp_q = '{8'h53, 8'h30, 8'h34, 8'h32, 8'h37, 8'h0D, 8'h0A};
        check_stream("t3a");
        req_score(14'd12000);
        exp_q = '{8'h53, 8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A};
        check_stream("t3b");

        // T5: score request while an event byte is on the wire, 3 events queued
        stall = 1'b1;
        push_one(LEFT);
        wait_rx("t5_first", 1);
        push_one(RIGHT);
        push_one(DROP);
        push_one(ROTATE);
        req_score(14'd55);
        repeat (4) @(negedge clk);
        stall = 1'b0;
        exp_q = '{8'h61, 8'h53, 8'h30, 8'h30, 8'h35, 8'h35, 8'h0D, 8'h0A, 8'h64, 8'h73, 8'h78};
        check_stream("t5");

        // T6: NOEVENT ignored, latest of two blocked score requests wins
        stall = 1'b1;
        push_one(HOLD);
        wait_rx("t6_first", 1);
        push_one(NOEVENT);
        req_score(14'd5);
        @(negedge clk);
        req_score(14'd6);
        repeat (4) @(negedge clk);
        stall = 1'b0;
        exp_q = '{8'h63, 8'h53, 8'h30, 8'h30, 8'h30, 8'h36, 8'h0D, 8'h0A};
        check_stream("t6");

        // T4: fill the FIFO while the uart is stalled, then overflow it
        stall = 1'b1;
        push_one(LEFT);
        wait_rx("t4_first", 1);
        for (int i = 0; i < DEPTH; i++) push_one(control_type'(3'((i % 7) + 1)));
        check("t4_ready_full", 32'(event_ready), 32'd0);
        check("t4_ovf_before", 32'(overflow), 32'd0);
        push_one(ROTATE);
        push_one(HOLD);
        check("t4_ovf_after", 32'(overflow), 32'd1);
        check("t4_ready_still", 32'(event_ready), 32'd0);
        stall = 1'b0;
        exp_q.push_back(8'h61);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(ascii_of(control_type'(3'((i % 7) + 1))));
        check_stream("t4");
        check("t4_ready_drained", 32'(event_ready), 32'd1);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        check("protocol_errors", 32'(proto_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
